sub_share_arbiter: RTL and testbench
====================================

Name: sub_share_arbiter

Overview:
- Shares one W-bit sign-magnitude subtractor core among NREQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- A round-robin arbiter grants one requester at a time, sequences the shared core, and returns sign, magnitude and requester ID on a single response channel with backpressure.
- Sits between requester blocks and the existing sign-magnitude subtraction datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 2, operand and magnitude width.
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*W  packed minuends; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed subtrahends, same packing.
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sign  out  1  1 when a < b.
- rsp_mag  out  W  |a - b|.
- done_cnt  out  8  completed-response counter; wraps 255 -> 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_sign=0; rsp_mag=0; done_cnt=0.
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is high, pick the winner: the first set bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in that cycle, so a handshake occurs.
  - Latch a, b and winner into op_a, op_b, op_id. Next state is EXEC.
  - If no req_valid bit is high, stay in IDLE with req_ready=0.
- EXEC:
  - The shared core computes from op_a and op_b.
  - At the clock edge, register sign, mag and op_id into the rsp_* outputs. Next state is RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_* values stay stable until the handshake.
  - On rsp_valid & rsp_ready: done_cnt++, rr_ptr=(op_id+1) mod NREQ, next state is IDLE, and rsp_valid drops the next cycle.
  - Without rsp_ready, stay in RESP with all outputs held.
- Latency: request accept at cycle T gives rsp_valid high at T+2. Minimum issue interval is 3 cycles.
- Arithmetic:
  - sign = (a < b) as unsigned W-bit values.
  - mag = sign ? b-a : a-b, held to W bits; it never overflows.
  - a == b gives sign=0, mag=0. There is no negative zero.
- Fairness: a requester that holds valid is served within NREQ grants.
- Boundary conditions:
  - Requests that arrive while in EXEC or RESP are ignored (req_ready=0). Requesters must hold valid, a and b stable until they see ready.
  - A requester that drops valid before grant is not served and leaves no state.
  - rr_ptr wraps NREQ-1 -> 0.
  - done_cnt wraps 255 -> 0 without a flag.
  - A winner index with no corresponding requester cannot occur because the scan is limited to NREQ.
- Reset mid-operation: any in-flight op is discarded and all outputs return to their reset values immediately. Nothing is replayed after reset.
- X on rsp_ready while rsp_valid=1 is a protocol violation and is flagged by a bench assertion.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - defaults for W and NREQ;
  - a packed response struct/typedef {id, sign, mag}.
- Sub-module sub_sm_core: purely combinational W-bit sign-magnitude subtractor (a, b -> sign, mag). It is instantiated once in sub_share_arbiter, which contains the FSM, round-robin logic, operand registers and counter.

Test Plan:
- Single request, NREQ=4, W=2: requester 1 sends a=1, b=3, rsp_ready=1 → req_ready=4'b0010 in the accept cycle; 2 cycles later rsp_valid=1 with id=1, sign=1, mag=2; done_cnt=1.
- Sign and equality cases: (3,1) → sign=0, mag=2. (2,2) → sign=0, mag=0. (0,3) → sign=1, mag=3.
- Round-robin: all four requesters hold valid continuously → grant order 0,1,2,3,0; each grant is 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stay stable, req_ready stays 0, done_cnt is unchanged; release → rsp_valid drops the next cycle and the next grant comes the cycle after.
- Reset mid-op: assert rst_n=0 during EXEC → rsp_valid=0 and done_cnt=0 immediately (asynchronous); after release the next grant starts at requester 0.
- Counter wrap: 256 back-to-back completions → done_cnt reads 0; results stay correct across the wrap.

Source files
------------

// File: rtl/sub_share_arbiter_pkg.sv
// Shared types and defaults for the time-shared sign-magnitude subtractor.
// Holds the FSM encoding and the packed response record.
package sub_share_arbiter_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 2;
    localparam int DEF_IDW  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_IDW-1:0] id;
        logic               sign;
        logic [DEF_W-1:0]   mag;
    } rsp_t;

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Requester and response channels of the shared subtractor.
// master = requester/consumer side, slave = arbiter side.
interface sub_share_arbiter_if
    import sub_share_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = DEF_IDW
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_sign;
    logic [W-1:0]      rsp_mag;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sign, rsp_mag
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sign, rsp_mag
    );
endinterface

// File: rtl/sub_share_arbiter_core.sv
// Combinational W-bit subtractor returning sign and magnitude of a - b.
// Latency: 0 cycles. Backpressure: none, purely combinational.
// Equal operands give sign 0 and magnitude 0, so there is no negative zero.
module sub_sm_core
    import sub_share_arbiter_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         sign,
    output logic [W-1:0] mag
);
    assign sign = (a < b);
    assign mag  = sign ? (b - a) : (a - b);
endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude subtractor among NREQ requesters.
// Latency: accept at T -> rsp_valid at T+2; one op in flight, issue interval 3 cycles.
// Backpressure: RESP holds all outputs until rsp_ready; no request is accepted meanwhile.
module sub_share_arbiter
    import sub_share_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = DEF_IDW
) (
    input  logic                clk,
    input  logic                rst_n,
    sub_share_arbiter_if.slave  bus,
    output logic [7:0]          done_cnt
);
    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] op_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           core_sign;
    logic [W-1:0]   core_mag;

    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [IDW:0]   scan_idx;

    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_sign_q;
    logic [W-1:0]   rsp_mag_q;

    // First valid requester at or after rr_ptr, wrapping within NREQ.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ))
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            if (!win_vld && bus.req_valid[scan_idx[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = scan_idx[IDW-1:0];
            end
        end
    end

    assign bus.req_ready = (rst_n && state == IDLE && win_vld) ? (NREQ'(1) << win_id) : '0;

    sub_sm_core #(.W(W)) u_core (
        .a    (op_a),
        .b    (op_b),
        .sign (core_sign),
        .mag  (core_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_id       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sign_q  <= 1'b0;
            rsp_mag_q   <= '0;
            done_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        op_a  <= bus.req_a[win_id*W +: W];
                        op_b  <= bus.req_b[win_id*W +: W];
                        op_id <= win_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id_q    <= op_id;
                    rsp_sign_q  <= core_sign;
                    rsp_mag_q   <= core_mag;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_cnt    <= done_cnt + 8'd1;
                        rr_ptr      <= (op_id == IDW'(NREQ-1)) ? '0 : op_id + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sign  = rsp_sign_q;
    assign bus.rsp_mag   = rsp_mag_q;
endmodule

// File: tb/tb_sub_share_arbiter.sv
// Scoreboard bench for sub_share_arbiter: results are predicted at request accept
// and compared when the response handshake happens.
module tb_sub_share_arbiter;
    import sub_share_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] done_cnt;

    sub_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    sub_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    bit   hold_valid = 1'b0;
    rsp_t sbq[$];

    always @(posedge clk)
        if (rst_n && bus.rsp_valid)
            assert (!$isunknown(bus.rsp_ready)) else $error("rsp_ready unknown while rsp_valid high");

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic rsp_t model(int id, int a, int b);
        int   d;
        rsp_t r;
        d      = a - b;
        r.id   = IDW'(id);
        r.sign = (d < 0);
        r.mag  = W'((d < 0) ? -d : d);
        return r;
    endfunction

    // One cycle: sample at negedge+1, apply post-handshake input changes after the posedge.
    task automatic tick(output bit acc, output int acc_id, output bit hs,
                        output rsp_t got, output rsp_t exp);
        #1;
        acc = 1'b0; acc_id = -1; hs = 1'b0; got = '0; exp = '0;
        for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                acc    = 1'b1;
                acc_id = i;
                sbq.push_back(model(i, int'(bus.req_a[i*W +: W]), int'(bus.req_b[i*W +: W])));
            end
        if (bus.rsp_valid && bus.rsp_ready) begin
            hs       = 1'b1;
            got.id   = bus.rsp_id;
            got.sign = bus.rsp_sign;
            got.mag  = bus.rsp_mag;
            if (sbq.size() > 0) exp = sbq.pop_front();
            else                exp = 'x;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            if (hold_valid) begin
                bus.req_a[acc_id*W +: W] = W'($urandom);
                bus.req_b[acc_id*W +: W] = W'($urandom);
            end else begin
                bus.req_valid[acc_id] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.req_a = '1;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_sign !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_sign: got %b want 0", bus.rsp_sign); end
        n_vec++; if (bus.rsp_mag !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_mag: got %0d want 0", bus.rsp_mag); end
        n_vec++; if (done_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit acc, hs; int aid; rsp_t got, exp, lit;
        lit = '{id: 2'd1, sign: 1'b1, mag: 2'd2};
        bus.req_a[1*W +: W] = 2'd1;
        bus.req_b[1*W +: W] = 2'd3;
        bus.req_valid[1] = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_grant: got %b want 0010", bus.req_ready); end
        tick(acc, aid, hs, got, exp);
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_exec_valid: got %b want 0", bus.rsp_valid); end
        tick(acc, aid, hs, got, exp);
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: rsp_valid got %b want 1 at T+2", bus.rsp_valid); end
        tick(acc, aid, hs, got, exp);
        n_vec++; if (!hs || got !== exp) begin n_bad++; $display("FAIL single_sb: hs=%b got %h want %h", hs, got, exp); end
        n_vec++; if (got !== lit) begin n_bad++; $display("FAIL single_result: got %h want %h", got, lit); end
        #1;
        n_vec++; if (done_cnt !== 8'd1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", bus.rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_sign_cases();
        bit acc, hs; int aid; rsp_t got, exp;
        int ta[3]  = '{3, 2, 0};
        int tbv[3] = '{1, 2, 3};
        int tid[3] = '{2, 3, 0};
        int es[3]  = '{0, 0, 1};
        int em[3]  = '{2, 0, 3};
        for (int t = 0; t < 3; t++) begin
            bus.req_a[tid[t]*W +: W] = W'(ta[t]);
            bus.req_b[tid[t]*W +: W] = W'(tbv[t]);
            bus.req_valid[tid[t]] = 1'b1;
            hs = 1'b0;
            for (int c = 0; c < 10 && !hs; c++) tick(acc, aid, hs, got, exp);
            n_vec++;
            if (!hs) begin n_bad++; $display("FAIL sign_case%0d: no response within 10 cycles", t); end
            else if (got !== exp) begin n_bad++; $display("FAIL sign_case%0d_sb: got %h want %h", t, got, exp); end
            n_vec++;
            if (int'(got.sign) != es[t] || int'(got.mag) != em[t] || int'(got.id) != tid[t]) begin
                n_bad++;
                $display("FAIL sign_case%0d_table: got id%0d s%0d m%0d want id%0d s%0d m%0d",
                         t, got.id, got.sign, got.mag, tid[t], es[t], em[t]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit acc, hs; int aid; rsp_t got, exp;
        int order[$]; int when[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        hold_valid = 1'b1;
        bus.req_a = 8'h1b;
        bus.req_b = 8'he4;
        bus.req_valid = '1;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick(acc, aid, hs, got, exp);
            if (acc) begin order.push_back(aid); when.push_back(c); end
            if (hs) begin
                n_vec++; if (got !== exp) begin n_bad++; $display("FAIL rr_sb: got %h want %h", got, exp); end
            end
        end
        hold_valid = 1'b0;
        bus.req_valid = '0;
        n_vec++;
        if (order.size() != 5) begin n_bad++; $display("FAIL rr_count: got %0d grants want 5", order.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++; if (order[i] != exp_order[i]) begin n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, order[i], exp_order[i]); end
                if (i > 0) begin
                    n_vec++; if (when[i] - when[i-1] != 3) begin n_bad++; $display("FAIL rr_spacing%0d: got %0d want 3", i, when[i] - when[i-1]); end
                end
            end
        end
        for (int c = 0; c < 10 && sbq.size() > 0; c++) begin
            tick(acc, aid, hs, got, exp);
            if (hs) begin
                n_vec++; if (got !== exp) begin n_bad++; $display("FAIL rr_drain_sb: got %h want %h", got, exp); end
            end
        end
        n_vec++; if (sbq.size() != 0) begin n_bad++; $display("FAIL rr_drain: %0d pending want 0", sbq.size()); end
    endtask

    task automatic test_backpressure();
        bit acc, hs, seen; int aid; rsp_t got, exp, hold, cur; logic [7:0] c0;
        bus.rsp_ready = 1'b0;
        bus.req_a[3*W +: W] = 2'd0;
        bus.req_b[3*W +: W] = 2'd2;
        bus.req_valid[3] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(acc, aid, hs, got, exp);
            #1;
            if (bus.rsp_valid) begin seen = 1'b1; break; end
        end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL bp_wait: rsp_valid never rose"); end
        hold = (sbq.size() > 0) ? sbq[0] : 'x;
        c0 = done_cnt;
        bus.req_a[0*W +: W] = 2'd3;
        bus.req_b[0*W +: W] = 2'd0;
        bus.req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) #1;
            cur.id = bus.rsp_id; cur.sign = bus.rsp_sign; cur.mag = bus.rsp_mag;
            n_vec++; if (cur !== hold || bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d: got v%b %h want v1 %h", i, bus.rsp_valid, cur, hold); end
            n_vec++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0000", i, bus.req_ready); end
            n_vec++; if (done_cnt !== c0) begin n_bad++; $display("FAIL bp_cnt%0d: got %0d want %0d", i, done_cnt, c0); end
            tick(acc, aid, hs, got, exp);
        end
        bus.rsp_ready = 1'b1;
        tick(acc, aid, hs, got, exp);
        n_vec++; if (!hs || got !== exp) begin n_bad++; $display("FAIL bp_release_sb: hs=%b got %h want %h", hs, got, exp); end
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop: rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_next_grant: got %b want 0001", bus.req_ready); end
        hs = 1'b0;
        for (int c = 0; c < 10 && !hs; c++) tick(acc, aid, hs, got, exp);
        n_vec++; if (!hs || got !== exp) begin n_bad++; $display("FAIL bp_next_sb: hs=%b got %h want %h", hs, got, exp); end
    endtask

    task automatic test_reset_mid();
        bit acc, hs; int aid, nhs; rsp_t got, exp;
        bus.rsp_ready = 1'b1;
        bus.req_a[2*W +: W] = 2'd1;
        bus.req_b[2*W +: W] = 2'd2;
        bus.req_valid[2] = 1'b1;
        tick(acc, aid, hs, got, exp);
        n_vec++; if (!acc || aid != 2) begin n_bad++; $display("FAIL mid_accept: acc=%b id=%0d want 1/2", acc, aid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_vec++; if (done_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_done_cnt: got %0d want 0", done_cnt); end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_a[0*W +: W] = 2'd2; bus.req_b[0*W +: W] = 2'd1;
        bus.req_a[2*W +: W] = 2'd0; bus.req_b[2*W +: W] = 2'd0;
        bus.req_valid = 4'b0101;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
        nhs = 0;
        for (int c = 0; c < 15 && nhs < 2; c++) begin
            tick(acc, aid, hs, got, exp);
            if (hs) begin
                nhs++;
                n_vec++; if (got !== exp) begin n_bad++; $display("FAIL mid_after_sb: got %h want %h", got, exp); end
            end
        end
        n_vec++; if (nhs != 2) begin n_bad++; $display("FAIL mid_after_count: got %0d want 2", nhs); end
    endtask

    task automatic test_wrap();
        bit acc, hs; int aid, nhs; rsp_t got, exp;
        do_reset();
        bus.rsp_ready = 1'b1;
        hold_valid = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = W'($urandom);
            bus.req_b[i*W +: W] = W'($urandom);
        end
        bus.req_valid = '1;
        nhs = 0;
        for (int c = 0; c < 900 && nhs < 256; c++) begin
            tick(acc, aid, hs, got, exp);
            if (hs) begin
                nhs++;
                n_vec++; if (got !== exp) begin n_bad++; $display("FAIL wrap_sb%0d: got %h want %h", nhs, got, exp); end
                if (nhs == 255) begin
                    n_vec++; if (done_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", done_cnt); end
                end
            end
        end
        n_vec++; if (nhs != 256) begin n_bad++; $display("FAIL wrap_count: got %0d completions want 256", nhs); end
        n_vec++; if (done_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_done_cnt: got %0d want 0", done_cnt); end
        hold_valid = 1'b0;
        bus.req_valid = '0;
        for (int c = 0; c < 10 && sbq.size() > 0; c++) begin
            tick(acc, aid, hs, got, exp);
            if (hs) begin
                n_vec++; if (got !== exp) begin n_bad++; $display("FAIL wrap_drain_sb: got %h want %h", got, exp); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_sign_cases();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
